// File: rtl/ram_block_mover_if.sv
// Control and RAM-port signal bundle for ram_block_mover; master is the mover side,
// slave is the sequencer/RAM side.
interface ram_block_mover_if #(
  parameter int CAddrLen = 11,
  parameter int CDataLen = 8
);
  logic                AStart;
  logic [1:0]          AMode;
  logic [CAddrLen-1:0] ASrc;
  logic [CAddrLen-1:0] ADst;
  logic [CAddrLen:0]   ALen;
  logic [CDataLen-1:0] AFill;
  logic                AAbort;
  logic                ABusy;
  logic                ADone;
  logic [CAddrLen:0]   ACount;
  logic [CAddrLen-1:0] AAddrRd;
  logic                ARdEn;
  logic [CDataLen-1:0] AMisoRd;
  logic [CAddrLen-1:0] AAddrWr;
  logic [CDataLen-1:0] AMosiWr;
  logic                AWrEn;

  modport master (
    input  AStart, AMode, ASrc, ADst, ALen, AFill, AAbort, AMisoRd,
    output ABusy, ADone, ACount, AAddrRd, ARdEn, AAddrWr, AMosiWr, AWrEn
  );

  modport slave (
    output AStart, AMode, ASrc, ADst, ALen, AFill, AAbort, AMisoRd,
    input  ABusy, ADone, ACount, AAddrRd, ARdEn, AAddrWr, AMosiWr, AWrEn
  );
endinterface

// File: rtl/ram_block_mover.sv
// RAM block copy (asc/desc) and constant fill, 1 word/cycle; copy of N words finishes in
// N+2 cycles, fill in N+1. No backpressure: the RAM accepts a read and a write every cycle.
module ram_block_mover #(
  parameter int CAddrLen = 11,
  parameter int CDataLen = 8
) (
  input logic              AClk,
  input logic              AResetN,
  ram_block_mover_if.master Bus
);
  typedef enum logic [1:0] {Idle, Run, Drain, Done} state_t;

  localparam logic [1:0]          CModeAsc  = 2'b00;
  localparam logic [1:0]          CModeDesc = 2'b01;
  localparam logic [1:0]          CModeFill = 2'b10;
  localparam logic [1:0]          CModeRsvd = 2'b11;
  localparam logic [CAddrLen:0]   CMaxLen   = {1'b1, {CAddrLen{1'b0}}};
  localparam logic [CAddrLen:0]   CCntOne   = {{CAddrLen{1'b0}}, 1'b1};
  localparam logic [CAddrLen-1:0] CPtrOne   = {{(CAddrLen-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [1:0]          mode_q;
  logic [CDataLen-1:0] fill_q;
  logic [CAddrLen-1:0] rd_ptr_q, wr_ptr_q;
  logic [CAddrLen:0]   left_q, count_q;
  logic                rd_en_q, wr_en_q, busy_q, done_q;

  logic [CAddrLen:0]   len_d;
  logic [CAddrLen-1:0] rd_ptr_d, wr_ptr_d;
  logic                last_d;

  always_comb begin
    len_d    = (Bus.ALen > CMaxLen) ? CMaxLen : Bus.ALen;
    rd_ptr_d = (mode_q == CModeDesc) ? rd_ptr_q - CPtrOne : rd_ptr_q + CPtrOne;
    wr_ptr_d = (mode_q == CModeDesc) ? wr_ptr_q - CPtrOne : wr_ptr_q + CPtrOne;
    last_d   = (left_q == CCntOne) || Bus.AAbort;
  end

  always_ff @(posedge AClk or negedge AResetN) begin
    if (!AResetN) begin
      state_q  <= Idle;
      mode_q   <= '0;
      fill_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      left_q   <= '0;
      count_q  <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          done_q <= 1'b0;
          if (Bus.AStart) begin
            mode_q   <= Bus.AMode;
            fill_q   <= Bus.AFill;
            rd_ptr_q <= Bus.ASrc;
            wr_ptr_q <= Bus.ADst;
            left_q   <= len_d;
            count_q  <= '0;
            if (len_d == '0 || Bus.AMode == CModeRsvd) begin
              done_q  <= 1'b1;
              state_q <= Done;
            end else begin
              busy_q  <= 1'b1;
              state_q <= Run;
              if (Bus.AMode == CModeFill) wr_en_q <= 1'b1;
              else                        rd_en_q <= 1'b1;
            end
          end
        end
        Run: begin
          left_q <= left_q - CCntOne;
          if (mode_q == CModeFill) begin
            count_q  <= count_q + CCntOne;
            wr_ptr_q <= wr_ptr_q + CPtrOne;
            if (last_d) begin
              wr_en_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= Done;
            end
          end else begin
            // Each issued read becomes the pending write of the next cycle.
            wr_en_q <= rd_en_q;
            if (wr_en_q) begin
              count_q  <= count_q + CCntOne;
              wr_ptr_q <= wr_ptr_d;
            end
            if (last_d) begin
              rd_en_q <= 1'b0;
              state_q <= Drain;
            end else begin
              rd_ptr_q <= rd_ptr_d;
            end
          end
        end
        Drain: begin
          count_q  <= count_q + CCntOne;
          wr_ptr_q <= wr_ptr_d;
          wr_en_q  <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= Done;
        end
        Done: begin
          done_q  <= 1'b0;
          state_q <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign Bus.ABusy   = busy_q;
  assign Bus.ADone   = done_q;
  assign Bus.ACount  = count_q;
  assign Bus.AAddrRd = rd_ptr_q;
  assign Bus.ARdEn   = rd_en_q;
  assign Bus.AAddrWr = wr_ptr_q;
  assign Bus.AWrEn   = wr_en_q;
  // Copy data flows straight from the RAM read port into the write port.
  assign Bus.AMosiWr = !wr_en_q ? '0 : ((mode_q == CModeFill) ? fill_q : Bus.AMisoRd);
endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: behavioural dual-port RAM, write/read scoreboards, latency checks.
module tb_ram_block_mover;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int NW = 2048;

  logic AClk = 1'b0;
  logic AResetN = 1'b1;
  always #5 AClk = ~AClk;

  ram_block_mover_if #(.CAddrLen(AW), .CDataLen(DW)) bus ();
  ram_block_mover #(.CAddrLen(AW), .CDataLen(DW)) dut (
    .AClk   (AClk),
    .AResetN(AResetN),
    .Bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Dual-port RAM model; bk_* is a bench-side preload port.
  logic [DW-1:0] mem [NW];
  logic [DW-1:0] rd_dat = '0;
  logic          bk_we = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_dat = '0;
  always @(posedge AClk) begin
    if (bk_we) mem[bk_addr] <= bk_dat;
    else if (bus.AWrEn) mem[bus.AAddrWr] <= bus.AMosiWr;
    rd_dat <= bus.ARdEn ? mem[bus.AAddrRd] : '0;
  end
  assign bus.AMisoRd = rd_dat;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];

  always @(negedge AClk) begin
    if (AResetN) begin
      if (bus.AWrEn) begin
        if (wr_q.size() == 0) chk("wr_extra_addr", 32'(bus.AAddrWr), 32'hFFFF_FFFF);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", 32'(bus.AAddrWr), 32'(e.a));
          chk("wr_data", 32'(bus.AMosiWr), 32'(e.d));
        end
      end else begin
        chk("mosi_idle_zero", 32'(bus.AMosiWr), 32'd0);
      end
      if (bus.ARdEn) begin
        if (rd_q.size() == 0) chk("rd_extra_addr", 32'(bus.AAddrRd), 32'hFFFF_FFFF);
        else chk("rd_addr", 32'(bus.AAddrRd), 32'(rd_q.pop_front()));
      end
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bk_we = 1'b1; bk_addr = a; bk_dat = d;
    @(posedge AClk); #1;
    bk_we = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.ABusy),   0);
    chk({tag, "_done"},  32'(bus.ADone),   0);
    chk({tag, "_count"}, 32'(bus.ACount),  0);
    chk({tag, "_rden"},  32'(bus.ARdEn),   0);
    chk({tag, "_wren"},  32'(bus.AWrEn),   0);
    chk({tag, "_addrrd"}, 32'(bus.AAddrRd), 0);
    chk({tag, "_addrwr"}, 32'(bus.AAddrWr), 0);
    chk({tag, "_mosi"},  32'(bus.AMosiWr), 0);
  endtask

  // abort_cyc: -1 none, 0 together with start, k>0 in Run cycle k; restart_cyc: AStart while busy.
  task automatic run_op(input string nm, input logic [1:0] mode, input logic [AW-1:0] src,
                        input logic [AW-1:0] dst, input logic [AW:0] len, input logic [DW-1:0] fill,
                        input int abort_cyc, input int restart_cyc);
    int  n_eff, w, exp_done, exp_busy, exp_first, cyc, busy_n, done_cyc, first_wr;
    bit  is_fill, is_void;
    n_eff   = (int'(len) > NW) ? NW : int'(len);
    is_fill = (mode == 2'b10);
    is_void = (n_eff == 0) || (mode == 2'b11);
    w = is_void ? 0 : ((abort_cyc >= 1 && abort_cyc < n_eff) ? abort_cyc : n_eff);
    for (int i = 0; i < w; i++) begin
      wr_t e;
      logic [AW-1:0] ra;
      if (mode == 2'b01) begin ra = src - AW'(i); e.a = dst - AW'(i); end
      else begin ra = src + AW'(i); e.a = dst + AW'(i); end
      e.d = is_fill ? fill : mem[ra];
      wr_q.push_back(e);
      if (!is_fill) rd_q.push_back(ra);
    end
    exp_done  = is_void ? 1 : (is_fill ? w + 1 : w + 2);
    exp_busy  = is_void ? 0 : (is_fill ? w : w + 1);
    exp_first = is_void ? -1 : (is_fill ? 1 : 2);

    bus.AStart = 1'b1; bus.AMode = mode; bus.ASrc = src; bus.ADst = dst;
    bus.ALen = len; bus.AFill = fill; bus.AAbort = (abort_cyc == 0);
    @(posedge AClk); #1;
    bus.AStart = 1'b0; bus.AAbort = 1'b0;
    cyc = 1; busy_n = 0; done_cyc = -1; first_wr = -1;
    while (cyc <= NW + 20) begin
      bus.AAbort = (cyc == abort_cyc);
      bus.AStart = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        bus.AMode = 2'b10; bus.ADst = dst + 11'h040; bus.ALen = 3;
      end
      @(negedge AClk);
      if (bus.ABusy) busy_n++;
      if (bus.AWrEn && first_wr < 0) first_wr = cyc;
      if (bus.ADone) begin
        done_cyc = cyc;
        chk({nm, "_count"}, 32'(bus.ACount), 32'(w));
        break;
      end
      @(posedge AClk); #1;
      cyc++;
    end
    bus.AAbort = 1'b0; bus.AStart = 1'b0;
    chk({nm, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    chk({nm, "_first_wr"}, 32'(first_wr), 32'(exp_first));
    chk({nm, "_wr_left"}, 32'(wr_q.size()), 0);
    chk({nm, "_rd_left"}, 32'(rd_q.size()), 0);
    wr_q.delete();
    rd_q.delete();
    @(posedge AClk); #1;
    @(negedge AClk);
    chk({nm, "_idle_done"}, 32'(bus.ADone), 0);
    @(posedge AClk); #1;
  endtask

  initial begin
    bus.AStart = 1'b0; bus.AMode = '0; bus.ASrc = '0; bus.ADst = '0;
    bus.ALen = '0; bus.AFill = '0; bus.AAbort = 1'b0;
    #2 AResetN = 1'b0;
    repeat (2) @(posedge AClk);
    #1;
    chk_outputs_zero("rst");
    AResetN = 1'b1;
    @(posedge AClk); #1;

    // Oversize length clamps to the whole RAM; every word written exactly once.
    run_op("clamp", 2'b10, 11'h000, 11'h400, 12'hFFF, 8'h3C, -1, -1);
    chk("clamp_mem_3ff", 32'(mem[11'h3FF]), 32'h3C);
    chk("clamp_mem_400", 32'(mem[11'h400]), 32'h3C);

    run_op("fill", 2'b10, 11'h000, 11'h010, 12'd4, 8'hA5, -1, -1);
    for (int i = 0; i < 4; i++) chk("fill_readback", 32'(mem[11'h010 + i]), 32'hA5);

    for (int i = 0; i < 4; i++) poke(AW'(i), DW'(i + 1));
    run_op("cpy_asc", 2'b00, 11'h000, 11'h100, 12'd4, 8'h00, -1, -1);
    for (int i = 0; i < 4; i++) chk("cpy_asc_mem", 32'(mem[11'h100 + i]), 32'(i + 1));

    run_op("cpy_desc", 2'b01, 11'h003, 11'h004, 12'd4, 8'h00, -1, -1);
    for (int i = 0; i < 4; i++) chk("cpy_desc_mem", 32'(mem[11'h001 + i]), 32'(i + 1));

    poke(11'h7FE, 8'h11);
    poke(11'h7FF, 8'h22);
    run_op("wrap", 2'b00, 11'h7FE, 11'h200, 12'd4, 8'h00, -1, -1);
    chk("wrap_mem0", 32'(mem[11'h200]), 32'h11);
    chk("wrap_mem1", 32'(mem[11'h201]), 32'h22);
    chk("wrap_mem2", 32'(mem[11'h202]), 32'h01);
    chk("wrap_mem3", 32'(mem[11'h203]), 32'h01);

    run_op("cpy_abort", 2'b00, 11'h000, 11'h300, 12'd10, 8'h00, 3, -1);
    chk("cpy_abort_untouched", 32'(mem[11'h303]), 32'h3C);

    run_op("len0", 2'b00, 11'h000, 11'h300, 12'd0, 8'h00, -1, -1);
    run_op("mode_rsvd", 2'b11, 11'h000, 11'h300, 12'd5, 8'h00, -1, -1);
    run_op("fill_abort", 2'b10, 11'h000, 11'h340, 12'd8, 8'h5A, 3, -1);
    run_op("start_abort", 2'b10, 11'h000, 11'h350, 12'd3, 8'h66, 0, -1);
    run_op("busy_start", 2'b00, 11'h000, 11'h500, 12'd5, 8'h00, -1, 2);
    chk("busy_start_no_fill", 32'(mem[11'h540]), 32'h3C);

    // Reset in Run cycle 2 of a 6-word fill.
    wr_q.push_back('{a: 11'h600, d: 8'h77});
    bus.AStart = 1'b1; bus.AMode = 2'b10; bus.ADst = 11'h600; bus.ALen = 12'd6; bus.AFill = 8'h77;
    @(posedge AClk); #1;
    bus.AStart = 1'b0;
    @(posedge AClk); #1;
    AResetN = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    repeat (2) @(posedge AClk);
    #1;
    chk("midrst_kept", 32'(mem[11'h600]), 32'h77);
    chk("midrst_stop", 32'(mem[11'h601]), 32'h3C);
    chk("midrst_wr_left", 32'(wr_q.size()), 0);
    wr_q.delete();
    AResetN = 1'b1;
    @(posedge AClk); #1;
    run_op("post_rst", 2'b10, 11'h000, 11'h610, 12'd2, 8'h99, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
